// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
//   Shared types and constants for the instruction-memory responder:
//   the FSM state encoding, the canonical NOP instruction and fault codes.
// -----------------------------------------------------------------------------
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_t;

endpackage

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
//   Word array with one write port and one registered read port.
//   A read and a write to the same word on the same edge return the OLD
//   word (read-before-write). The read register clears on reset; the
//   array contents are never cleared.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (read register)
//   wr_en/wr_idx/wr_data write port
//   rd_en/rd_idx        read request, data appears on rd_data after the edge
//   rd_data             registered read data, held when rd_en is low
// -----------------------------------------------------------------------------
module inst_mem_array #(
    parameter int DEPTH  = 4096,
    parameter int INST_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [INST_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [INST_W-1:0] rd_data
);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//   Memory side of the instruction-fetch interface. Accepts one request at a
//   time, waits a programmable number of cycles, then returns the addressed
//   32-bit word (or an access fault) and holds it until the requester takes it.
//   Optional build macro: IMEM_RAND_LAT_EN adds 0..3 pseudo-random extra WAIT
//   cycles per request, drawn from a free-running 16-bit LFSR at accept.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready/req_addr   fetch request (byte address)
//   resp_valid/resp_ready          response handshake
//   resp_inst/resp_err             fetched word / access fault
//   ld_en/ld_idx/ld_data           loader write port into the word array
// -----------------------------------------------------------------------------
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                INST_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int                LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INST_W-1:0]        resp_inst,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [INST_W-1:0]        ld_data
);

    localparam int IDX_W = $clog2(DEPTH);
    // Wide enough for LATENCY (max 15) plus up to 3 random extra cycles.
    localparam int CNT_W = 5;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    wait_total;

`ifdef IMEM_RAND_LAT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign wait_total = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
    assign wait_total = CNT_W'(LATENCY);
`endif

    // Address classified and read on the edge that enters RESP.
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_off;
    logic [IDX_W-1:0]  rd_idx;
    fault_t            rd_fault;
    logic              rd_fire;
    logic [INST_W-1:0] rd_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_addr = addr_q;
        rd_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d = req_addr;
                    cnt_d  = wait_total;
                    if (wait_total == '0) begin
                        // Zero wait: the accept edge is also the read edge,
                        // so read straight from the request address.
                        state_d = RESP;
                        rd_addr = req_addr;
                        rd_fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    rd_fire = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        err_d   = rd_fire ? (rd_fault != FAULT_NONE) : err_q;
    end

    // Offset wraps for addresses below BASE_ADDR, which then fail the range test.
    always_comb begin
        rd_off   = rd_addr - BASE_ADDR;
        rd_idx   = rd_off[IDX_W+1:2];
        rd_fault = FAULT_NONE;
        if (rd_addr[1:0] != 2'b00) begin
            rd_fault = FAULT_MISALIGN;
        end else if ((rd_off >> 2) >= ADDR_W'(DEPTH)) begin
            rd_fault = FAULT_RANGE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    inst_mem_array #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ld_en),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .rd_en   (rd_fire && (rd_fault == FAULT_NONE)),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign req_ready  = ready_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    // A faulted access never touches the array, so mask the stale read data.
    assign resp_inst  = err_q ? '0 : rd_data;

endmodule
